// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches the instruction at the current PC over req/ack,
// presents it to decode over valid/ready, and steps or redirects the PC.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int PC_INCREMENT = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_address
);
  typedef enum logic [1:0] {IDLE, REQUEST, UPDATE, HOLD} state_t;
  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INCREMENT);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d, redir_addr_q, redir_addr_d;
  logic instr_valid_q, instr_valid_d, redir_pend_q, redir_pend_d;
  assign mem_req      = state_q == REQUEST;
  assign mem_addr     = mem_req ? pc_address : '0;
  assign pc_write     = state_q == UPDATE;
  assign next_address = !pc_write ? '0 : redir_pend_q ? redir_addr_q : instr_pc_q + INC;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    redir_pend_d  = redir_pend_q | redirect;
    redir_addr_d  = redirect ? redirect_address : redir_addr_q;
    case (state_q)
      IDLE: state_d = redirect ? UPDATE : REQUEST;
      REQUEST: if (mem_ack) begin
        state_d = UPDATE;
        // a redirect seen during or with the request squashes the returned data
        if (!redir_pend_d) begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_address;
        end
      end
      UPDATE: begin
        redir_pend_d  = redirect;
        state_d       = redirect ? UPDATE : redir_pend_q ? REQUEST : HOLD;
        instr_valid_d = !redirect && !redir_pend_q;
      end
      HOLD: begin
        instr_valid_d = !redirect && !instr_ready;
        state_d       = redirect ? UPDATE : instr_ready ? REQUEST : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      redir_pend_q  <= redir_pend_d;
      redir_addr_q  <= redir_addr_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: PC model, memory responder and decode sink around the
// fetch unit; fetched words are queued on ack and compared when decode accepts them.
module tb_instruction_fetch_unit;
  logic clock = 0, reset_n = 0;
  logic [15:0] pc_address, next_address, mem_addr, instr, instr_pc;
  logic [15:0] mem_rdata = 0, redirect_address = 0;
  logic pc_write, mem_req, instr_valid;
  logic mem_ack = 0, instr_ready = 0, redirect = 0;
  typedef struct {logic [15:0] pc; int ack_d; int rdy_d; int n;} vec_t;
  typedef struct {logic [15:0] a; logic [15:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  vec_t vecs[5];
  int checks = 0, failures = 0;
  int ack_delay = 0, ready_delay = 0, rcnt = 0, vcnt = 0, accepted = 0;
  logic run = 0, squash = 0, no_len = 0;
  logic [15:0] pc_init = 0, redir_target = 0, exp_next = 0, req_addr = 0, held = 0;

  instruction_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .pc_address(pc_address), .pc_write(pc_write),
    .next_address(next_address), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_address(redirect_address)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pc_address <= pc_init;
    else if (pc_write) pc_address <= next_address;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  always @(negedge clock) if (reset_n && run) begin
    if (instr_valid) begin
      if (vcnt > 0) check("hold_stable", 64'({mem_req, pc_write, instr}), 64'({2'b00, held}));
      held = instr;
      instr_ready = vcnt >= ready_delay;
      vcnt++;
      if (instr_ready) begin
        if (q.size() == 0) check("accept_unexpected", 64'(instr_pc), 64'hFFFF_FFFF);
        else begin
          e = q.pop_front();
          check("instr_pc", 64'(instr_pc), 64'(e.a));
          check("instr", 64'(instr), 64'(e.d));
        end
        accepted++;
      end
    end else begin
      if (vcnt > 0 && !no_len) check("valid_len", 64'(vcnt), 64'(ready_delay + 1));
      vcnt = 0;
      no_len = 0;
      instr_ready = 0;
    end
    if (pc_write) check("next_address", 64'(next_address), 64'(exp_next));
    if (mem_req) begin
      if (rcnt > 0) check("req_hold", 64'(mem_addr), 64'(req_addr));
      req_addr = mem_addr;
      if (rcnt >= ack_delay) begin
        mem_ack = 1;
        mem_rdata = mem_addr ^ 16'h5A3C;
        if (!squash) q.push_back('{mem_addr, mem_rdata});
        exp_next = squash ? redir_target : mem_addr + 16'd2;
        squash = 0;
      end else begin
        mem_ack = 0;
        mem_rdata = 16'($urandom);
      end
      rcnt++;
    end else begin
      mem_ack = 0;
      rcnt = 0;
    end
  end

  task automatic do_reset(input logic [15:0] p);
    run = 0;
    reset_n = 0;
    pc_init = p;
    redirect = 0;
    mem_ack = 0;
    instr_ready = 0;
    q.delete();
    rcnt = 0;
    vcnt = 0;
    squash = 0;
    no_len = 0;
    accepted = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ctl", 64'({mem_req, pc_write, instr_valid}), 64'(0));
    check("reset_data", {next_address, instr, instr_pc, mem_addr}, 64'(0));
    reset_n = 1;
    run = 1;
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (accepted < n && t < 300) begin
      @(posedge clock);
      t++;
    end
    check("accept_count", 64'(accepted), 64'(n));
  endtask

  task automatic wait_sig(input bit want_valid);
    int t = 0;
    while ((want_valid ? !instr_valid : !mem_req) && t < 100) begin
      @(negedge clock);
      t++;
    end
    check(want_valid ? "wait_valid" : "wait_req", 64'(t < 100), 64'(1));
  endtask

  initial begin
    vecs[0] = '{16'h0000, 0, 0, 3};
    vecs[1] = '{16'h0100, 0, 5, 2};
    vecs[2] = '{16'h0040, 4, 0, 2};
    vecs[3] = '{16'hFFFE, 1, 1, 2};
    vecs[4] = '{16'h7FFE, 2, 2, 3};
    foreach (vecs[i]) begin
      ack_delay = vecs[i].ack_d;
      ready_delay = vecs[i].rdy_d;
      do_reset(vecs[i].pc);
      wait_acc(vecs[i].n);
    end
    // redirect while a request is outstanding: returned data must be dropped
    ack_delay = 4;
    ready_delay = 0;
    do_reset(16'h0010);
    wait_acc(1);
    wait_sig(0);
    @(posedge clock);
    #1;
    redirect = 1;
    redirect_address = 16'h1234;
    redir_target = 16'h1234;
    squash = 1;
    @(posedge clock);
    #1;
    redirect = 0;
    wait_acc(2);
    // redirect while holding an instruction that decode has not taken
    ack_delay = 0;
    ready_delay = 100;
    do_reset(16'h0020);
    wait_sig(1);
    @(posedge clock);
    #1;
    redirect = 1;
    redirect_address = 16'h2000;
    redir_target = 16'h2000;
    exp_next = 16'h2000;
    no_len = 1;
    void'(q.pop_front());
    @(posedge clock);
    #1;
    redirect = 0;
    check("hold_redir_drop", 64'(instr_valid), 64'(0));
    ready_delay = 0;
    wait_acc(1);
    // asynchronous reset in the middle of a request
    ack_delay = 10;
    do_reset(16'h0040);
    wait_sig(0);
    @(posedge clock);
    #2;
    check("pre_async_req", 64'(mem_req), 64'(1));
    run = 0;
    reset_n = 0;
    #1;
    check("async_drop", 64'({mem_req, pc_write, instr_valid}), 64'(0));
    ack_delay = 0;
    do_reset(16'h0300);
    wait_acc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
